// File: rtl/pcs_am_pkg.sv
// Purpose: shared constants, AM table and FSM state type for the AM lock / deskew path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pcs_am_pkg;

    localparam int NB_CODED_BLOCK = 66;
    localparam int N_LANES        = 20;
    localparam int DEF_AM_PERIOD  = 16384;
    localparam int MAX_INVALID_AM = 8;
    localparam int NB_INVALID_CNT = $clog2(MAX_INVALID_AM) + 1;
    localparam int NB_LANE_ID     = $clog2(N_LANES);
    localparam int NB_AM_WORD     = 24;

    // {M0,M1,M2} for each PCS lane, IEEE 802.3 Table 82-2
    localparam logic [NB_AM_WORD-1:0] AM_TABLE [N_LANES] = '{
        24'hC16821, 24'h9D718E, 24'h594BE8, 24'h4D957B, 24'hF50709,
        24'hDD14C2, 24'h9A4A26, 24'h7B4566, 24'hA02476, 24'h68C9FB,
        24'hFD6C99, 24'hB99155, 24'h5CB9B2, 24'h1AF8BD, 24'h83C7CA,
        24'h3536CD, 24'hC4314C, 24'hADD6B7, 24'h5F662A, 24'hC0F0E5
    };

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_CONFIRM = 2'd1,
        ST_LOCKED  = 2'd2
    } am_state_e;

endpackage

// File: rtl/am_lock_module_if.sv
// Purpose: block stream into the AM lock stage and tagged stream out towards deskew.
// Latency: n/a (signal bundle only).
// Backpressure: none; the stream is valid-only, the consumer must accept every block.
interface am_lock_module_if;
    import pcs_am_pkg::*;

    logic                      i_valid;
    logic [NB_CODED_BLOCK-1:0] i_data;
    logic                      i_block_lock;
    logic [NB_CODED_BLOCK-1:0] o_data;
    logic                      o_valid;
    logic                      o_am_flag;
    logic [NB_LANE_ID-1:0]     o_lane_id;
    logic                      o_am_lock;

    // upstream block_sync side plus downstream consumer
    modport master (
        output i_valid, i_data, i_block_lock,
        input  o_data, o_valid, o_am_flag, o_lane_id, o_am_lock
    );

    // the AM lock stage itself
    modport slave (
        input  i_valid, i_data, i_block_lock,
        output o_data, o_valid, o_am_flag, o_lane_id, o_am_lock
    );

endinterface

// File: rtl/am_match_table.sv
// Purpose: combinational check of one 66-bit block against the 20-entry AM table.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module am_match_table
    import pcs_am_pkg::*;
(
    input  logic [NB_CODED_BLOCK-1:0] i_block,
    output logic                      o_hit,
    output logic [NB_LANE_ID-1:0]     o_idx
);

    logic [NB_AM_WORD-1:0] am_word;
    logic [NB_AM_WORD-1:0] am_cword;
    logic                  framing_ok;
    logic [15:0]           unused_bip;

    // BIP3/BIP7 carry parity, not identity, so they take no part in matching
    assign unused_bip = {i_block[39:32], i_block[7:0]};
    assign am_word    = i_block[63:40];
    assign am_cword   = i_block[31:8];
    assign framing_ok = (i_block[65:64] == 2'b10) && (am_cword == ~am_word);

    // table search; entries are unique so at most one can hit
    always_comb begin
        o_hit = 1'b0;
        o_idx = '0;
        for (int i = 0; i < N_LANES; i++) begin
            if (framing_ok && (am_word == AM_TABLE[i])) begin
                o_hit = 1'b1;
                o_idx = NB_LANE_ID'(i);
            end
        end
    end

endmodule

// File: rtl/am_lock_module.sv
// Purpose: per-lane AM search/confirm/lock, tags AM blocks and reports the PCS lane ID.
// Latency: 1 cycle on o_data/o_valid/o_am_flag.
// Backpressure: none; only i_enable & i_valid cycles advance, otherwise state holds.
module am_lock_module
    import pcs_am_pkg::*;
#(
    parameter int AM_PERIOD = DEF_AM_PERIOD,
    parameter int NB_AM_CNT = $clog2(AM_PERIOD)
)
(
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_enable,
    input  logic [NB_INVALID_CNT-1:0] i_invalid_am_limit,
    am_lock_module_if.slave           lane_if
);

    localparam logic [NB_AM_CNT-1:0] AM_LAST = NB_AM_CNT'(AM_PERIOD - 1);

    am_state_e                 state_q, state_d;
    logic [NB_AM_CNT-1:0]      am_cnt_q, am_cnt_d;
    logic [NB_INVALID_CNT-1:0] invalid_cnt_q, invalid_cnt_d;
    logic [NB_LANE_ID-1:0]     lane_id_q, lane_id_d;
    logic                      am_flag_q, am_flag_d;
    logic [NB_CODED_BLOCK-1:0] data_q, data_d;
    logic                      valid_q, valid_d;

    logic                      hit;
    logic [NB_LANE_ID-1:0]     idx;
    logic                      blk_event;
    logic                      at_am_pos;
    logic                      lane_ok;
    logic [NB_INVALID_CNT-1:0] limit_eff;
    logic [NB_INVALID_CNT:0]   invalid_inc;

    am_match_table u_match (
        .i_block (lane_if.i_data),
        .o_hit   (hit),
        .o_idx   (idx)
    );

    assign blk_event   = i_enable & lane_if.i_valid;
    // explicit compare so non power-of-two periods wrap at the right place
    assign at_am_pos   = (am_cnt_q == AM_LAST);
    assign lane_ok     = hit && (idx == lane_id_q);
    assign limit_eff   = (i_invalid_am_limit == '0) ? NB_INVALID_CNT'(1) : i_invalid_am_limit;
    assign invalid_inc = {1'b0, invalid_cnt_q} + (NB_INVALID_CNT+1)'(1);

    // data pipeline: o_data holds across idle/disabled cycles
    always_comb begin
        data_d  = data_q;
        valid_d = lane_if.i_valid & i_enable;
        if (blk_event) begin
            data_d = lane_if.i_data;
        end
    end

    // lock FSM next-state; loss of block lock overrides everything
    always_comb begin
        state_d       = state_q;
        am_cnt_d      = am_cnt_q;
        invalid_cnt_d = invalid_cnt_q;
        lane_id_d     = lane_id_q;
        am_flag_d     = 1'b0;
        if (!lane_if.i_block_lock) begin
            state_d       = ST_SEARCH;
            am_cnt_d      = '0;
            invalid_cnt_d = '0;
            lane_id_d     = '0;
        end else if (blk_event) begin
            case (state_q)
                ST_SEARCH: begin
                    if (hit) begin
                        state_d   = ST_CONFIRM;
                        lane_id_d = idx;
                        am_cnt_d  = '0;
                        am_flag_d = 1'b1;
                    end
                end
                ST_CONFIRM: begin
                    if (at_am_pos) begin
                        am_cnt_d = '0;
                        if (lane_ok) begin
                            state_d   = ST_LOCKED;
                            am_flag_d = 1'b1;
                        end else begin
                            // this block is not retried as a first AM
                            state_d   = ST_SEARCH;
                            lane_id_d = '0;
                        end
                    end else begin
                        am_cnt_d = am_cnt_q + 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (at_am_pos) begin
                        am_cnt_d = '0;
                        if (lane_ok) begin
                            invalid_cnt_d = '0;
                            am_flag_d     = 1'b1;
                        end else if (invalid_inc >= {1'b0, limit_eff}) begin
                            state_d       = ST_SEARCH;
                            lane_id_d     = '0;
                            invalid_cnt_d = '0;
                        end else begin
                            invalid_cnt_d = invalid_inc[NB_INVALID_CNT-1:0];
                        end
                    end else begin
                        am_cnt_d = am_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_SEARCH;
                end
            endcase
        end
    end

    // state and pipeline registers
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q       <= ST_SEARCH;
            am_cnt_q      <= '0;
            invalid_cnt_q <= '0;
            lane_id_q     <= '0;
            am_flag_q     <= 1'b0;
            data_q        <= '0;
            valid_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            am_cnt_q      <= am_cnt_d;
            invalid_cnt_q <= invalid_cnt_d;
            lane_id_q     <= lane_id_d;
            am_flag_q     <= am_flag_d;
            data_q        <= data_d;
            valid_q       <= valid_d;
        end
    end

    assign lane_if.o_data    = data_q;
    assign lane_if.o_valid   = valid_q;
    assign lane_if.o_am_flag = am_flag_q;
    assign lane_if.o_lane_id = lane_id_q;
    assign lane_if.o_am_lock = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_am_lock_module.sv
// Purpose: randomized + directed bench for am_lock_module against a block-count reference model.
// Latency: expects 1-cycle output latency.
// Backpressure: none; stream driven valid-only.
module tb_am_lock_module;

    localparam int P     = 16;
    localparam int HUNT  = 0;
    localparam int TRIAL = 1;
    localparam int HELD  = 2;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       en    = 1'b0;
    logic [3:0] lim   = 4'd3;

    am_lock_module_if lif();

    am_lock_module #(.AM_PERIOD(P)) dut (
        .i_clock            (clk),
        .i_reset            (rst_n),
        .i_enable           (en),
        .i_invalid_am_limit (lim),
        .lane_if            (lif)
    );

    always #5 clk = ~clk;

    // independent copy of the 802.3 lane markers {M0,M1,M2}
    logic [23:0] tab [20] = '{
        24'hC16821, 24'h9D718E, 24'h594BE8, 24'h4D957B, 24'hF50709,
        24'hDD14C2, 24'h9A4A26, 24'h7B4566, 24'hA02476, 24'h68C9FB,
        24'hFD6C99, 24'hB99155, 24'h5CB9B2, 24'h1AF8BD, 24'h83C7CA,
        24'h3536CD, 24'hC4314C, 24'hADD6B7, 24'h5F662A, 24'hC0F0E5
    };

    int n_tot = 0;
    int n_bad = 0;

    // reference model: lock tracked as "which valid block number is the next AM due at"
    int          m_mode, m_lane, m_bad, m_ev, m_next;
    logic        m_valid, m_flag;
    logic [65:0] m_data;

    task automatic chk(input string tag, input logic [65:0] got, input logic [65:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_mode = HUNT; m_lane = 0; m_bad = 0; m_ev = 0; m_next = 0;
        m_valid = 1'b0; m_flag = 1'b0; m_data = '0;
    endfunction

    function automatic void lookup(input logic [65:0] d, output bit hit, output int idx);
        hit = 1'b0;
        idx = 0;
        if (d[65:64] == 2'b10 && d[31:8] == ~d[63:40]) begin
            for (int i = 0; i < 20; i++) begin
                if (tab[i] == d[63:40]) begin
                    hit = 1'b1;
                    idx = i;
                end
            end
        end
    endfunction

    function automatic void model_step(input logic v, input logic e, input logic [65:0] d,
                                       input logic bl, input logic [3:0] l);
        bit hit;
        int idx;
        int thr;
        m_valid = v & e;
        m_flag  = 1'b0;
        if (v & e) m_data = d;
        if (!bl) begin
            m_mode = HUNT; m_lane = 0; m_bad = 0;
        end else if (v & e) begin
            m_ev++;
            lookup(d, hit, idx);
            if (m_mode == HUNT) begin
                if (hit) begin
                    m_mode = TRIAL; m_lane = idx; m_next = m_ev + P; m_flag = 1'b1;
                end
            end else if (m_ev == m_next) begin
                m_next = m_ev + P;
                if (hit && idx == m_lane) begin
                    if (m_mode == TRIAL) m_mode = HELD;
                    m_bad  = 0;
                    m_flag = 1'b1;
                end else if (m_mode == TRIAL) begin
                    m_mode = HUNT; m_lane = 0;
                end else begin
                    m_bad++;
                    thr = (l == 0) ? 1 : int'(l);
                    if (m_bad >= thr) begin
                        m_mode = HUNT; m_lane = 0; m_bad = 0;
                    end
                end
            end
        end
    endfunction

    function automatic logic [65:0] fill_blk();
        return {2'b01, $urandom, $urandom};
    endfunction

    // kind: 0 good, 1 bad complement, 2 bad sync header, 3 other lane, 4 corrupted marker
    function automatic logic [65:0] am_blk(input int lane, input int kind);
        logic [23:0] m;
        logic [23:0] c;
        logic [1:0]  sh;
        int          b;
        m  = tab[lane];
        sh = 2'b10;
        if (kind == 3) m = tab[(lane + 1 + $urandom_range(0, 18)) % 20];
        c  = ~m;
        b  = $urandom_range(0, 23);
        if (kind == 1) c[b] = ~c[b];
        if (kind == 2) sh = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b11;
        if (kind == 4) m[b] = ~m[b];
        return {sh, m, 8'($urandom), c, 8'($urandom)};
    endfunction

    task automatic cyc(input logic v, input logic e, input logic [65:0] d, input logic bl);
        lif.i_valid      = v;
        lif.i_data       = d;
        lif.i_block_lock = bl;
        en               = e;
        @(posedge clk);
        model_step(v, e, d, bl, lim);
        #1;
        chk("valid", 66'(lif.o_valid), 66'(m_valid));
        chk("data", lif.o_data, m_data);
        chk("flag", 66'(lif.o_am_flag), 66'(m_flag));
        chk("lock", 66'(lif.o_am_lock), 66'(m_mode == HELD));
        chk("lane", 66'(lif.o_lane_id), 66'(m_lane));
    endtask

    task automatic drop();
        cyc(1'b0, 1'b1, fill_blk(), 1'b0);
    endtask

    // one AM period; gap cycles alternate "no valid" and "valid but disabled"
    task automatic period(input int lane, input int kind, input int gap);
        for (int k = 0; k < P; k++) begin
            for (int g = 0; g < gap; g++) cyc(g[0], !g[0], fill_blk(), 1'b1);
            cyc(1'b1, 1'b1, (k == 0) ? am_blk(lane, kind) : fill_blk(), 1'b1);
        end
    endtask

    task automatic rnd_phase(input int ncyc);
        int          pos;
        int          lane;
        int          kind;
        logic        v, e, bl;
        logic [65:0] d;
        pos  = 0;
        lane = $urandom_range(0, 19);
        for (int i = 0; i < ncyc; i++) begin
            e  = ($urandom_range(0, 19) != 0);
            v  = ($urandom_range(0, 3) != 0);
            bl = ($urandom_range(0, 499) != 0);
            if ($urandom_range(0, 299) == 0) lim = 4'($urandom_range(0, 8));
            if ($urandom_range(0, 399) == 0) begin
                lane = $urandom_range(0, 19);
                pos  = pos + $urandom_range(1, P - 1);
            end
            d = fill_blk();
            if (v && e) begin
                if (pos % P == 0) begin
                    kind = ($urandom_range(0, 9) < 8) ? 0 : $urandom_range(1, 4);
                    d    = am_blk(lane, kind);
                end
                pos++;
            end
            cyc(v, e, d, bl);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: sim time limit reached, total=%0d", n_tot);
        $fatal(1, "watchdog");
    end

    initial begin
        lif.i_valid      = 1'b0;
        lif.i_data       = '0;
        lif.i_block_lock = 1'b0;
        model_reset();
        #12;
        chk("rst_valid", 66'(lif.o_valid), 66'(0));
        chk("rst_data", lif.o_data, 66'(0));
        chk("rst_flag", 66'(lif.o_am_flag), 66'(0));
        chk("rst_lock", 66'(lif.o_am_lock), 66'(0));
        chk("rst_lane", 66'(lif.o_lane_id), 66'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: lane 0 AM at blocks 0 and 16
        cyc(1'b1, 1'b1, 66'h2_C168_2100_3E97_DE00, 1'b1);
        chk("p1_flag_first", 66'(lif.o_am_flag), 66'(1));
        repeat (15) cyc(1'b1, 1'b1, fill_blk(), 1'b1);
        chk("p1_no_lock_yet", 66'(lif.o_am_lock), 66'(0));
        cyc(1'b1, 1'b1, 66'h2_C168_2100_3E97_DE00, 1'b1);
        chk("p1_flag_second", 66'(lif.o_am_flag), 66'(1));
        chk("p1_lock", 66'(lif.o_am_lock), 66'(1));
        chk("p1_lane", 66'(lif.o_lane_id), 66'(0));

        // 2: lane 1 then lane 2 at the confirm position
        drop();
        period(1, 0, 0);
        period(2, 0, 0);
        chk("p2_lock", 66'(lif.o_am_lock), 66'(0));
        chk("p2_lane", 66'(lif.o_lane_id), 66'(0));
        period(2, 0, 0);
        chk("p2_confirm_lane", 66'(lif.o_lane_id), 66'(2));
        period(2, 0, 0);
        chk("p2_relock", 66'(lif.o_am_lock), 66'(1));

        // 3: lane 5, limit 3
        drop();
        lim = 4'd3;
        period(5, 0, 0);
        period(5, 0, 0);
        period(5, 1, 0);
        period(5, 3, 0);
        period(5, 0, 0);
        chk("p3_hold", 66'(lif.o_am_lock), 66'(1));
        period(5, 2, 0);
        period(5, 2, 0);
        chk("p3_hold2", 66'(lif.o_am_lock), 66'(1));
        period(5, 4, 0);
        chk("p3_unlock", 66'(lif.o_am_lock), 66'(0));
        // live limit reduction, then limit 0 acting as 1
        drop();
        period(5, 0, 0);
        period(5, 0, 0);
        period(5, 1, 0);
        period(5, 1, 0);
        chk("p3_two_bad", 66'(lif.o_am_lock), 66'(1));
        lim = 4'd1;
        period(5, 1, 0);
        chk("p3_live_lim", 66'(lif.o_am_lock), 66'(0));
        drop();
        period(5, 0, 0);
        period(5, 0, 0);
        lim = 4'd0;
        period(5, 3, 0);
        chk("p3_lim_zero", 66'(lif.o_am_lock), 66'(0));
        lim = 4'd3;

        // 4: block lock glitch mid-period
        drop();
        period(7, 0, 0);
        period(7, 0, 0);
        repeat (5) cyc(1'b1, 1'b1, fill_blk(), 1'b1);
        cyc(1'b1, 1'b1, fill_blk(), 1'b0);
        chk("p4_drop", 66'(lif.o_am_lock), 66'(0));
        repeat (10) cyc(1'b1, 1'b1, fill_blk(), 1'b1);
        period(7, 0, 0);
        chk("p4_one_am", 66'(lif.o_am_lock), 66'(0));
        period(7, 0, 0);
        chk("p4_relock", 66'(lif.o_am_lock), 66'(1));

        // 5: disabled window then sparse valids
        drop();
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 1'b0, fill_blk(), 1'b1);
            chk("p5_valid_dis", 66'(lif.o_valid), 66'(0));
        end
        period(9, 0, 2);
        period(9, 0, 2);
        chk("p5_lock", 66'(lif.o_am_lock), 66'(1));
        chk("p5_lane", 66'(lif.o_lane_id), 66'(9));

        // 6: async reset while locked, then bad-complement AMs
        drop();
        period(3, 0, 0);
        period(3, 0, 0);
        repeat (4) cyc(1'b1, 1'b1, fill_blk(), 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("p6_valid", 66'(lif.o_valid), 66'(0));
        chk("p6_data", lif.o_data, 66'(0));
        chk("p6_flag", 66'(lif.o_am_flag), 66'(0));
        chk("p6_lock", 66'(lif.o_am_lock), 66'(0));
        chk("p6_lane", 66'(lif.o_lane_id), 66'(0));
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        period(0, 1, 0);
        period(0, 1, 0);
        chk("p6_badc_lock", 66'(lif.o_am_lock), 66'(0));

        // randomized soak
        rnd_phase(3000);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule

// File: doc/am_lock_module.md
Name: am_lock_module

Overview:
- Per-PCS-lane alignment-marker (AM) lock stage, placed directly downstream of block_sync_module.
- Consumes 66-bit block-aligned data, valid and block_lock.
- Finds the periodic 100GBASE-R alignment marker, identifies which PCS lane (0..19) the physical lane carries, and declares am_lock after two consecutive good AMs spaced AM_PERIOD blocks apart.
- Passes data to the lane deskew/reorder stage with an AM flag and the lane ID.

Parameters:
NB_CODED_BLOCK, 66, coded block width
N_LANES, 20, number of PCS lanes / AM table entries
AM_PERIOD, 16384, blocks from one AM to the next (inclusive of AM)
NB_AM_CNT, $clog2(AM_PERIOD), block counter width
MAX_INVALID_AM, 8, max programmable invalid-AM limit
NB_INVALID_CNT, $clog2(MAX_INVALID_AM)+1, invalid counter width
NB_LANE_ID, $clog2(N_LANES), lane ID width

Ports:
i_clock  in  1  system clock
i_reset  in  1  asynchronous, active-low reset
i_enable  in  1  global enable; low freezes all state
i_valid  in  1  block valid from block_sync_module
i_data  in  NB_CODED_BLOCK  aligned block; [65:64] sync header, [63:56]=M0 ... [7:0]=BIP7
i_block_lock  in  1  block lock from block_sync_module
i_invalid_am_limit  in  NB_INVALID_CNT  consecutive bad AMs that drop lock (0 treated as 1)
o_data  out  NB_CODED_BLOCK  registered copy of i_data
o_valid  out  1  registered i_valid & i_enable
o_am_flag  out  1  high with the o_data block that is a matched AM
o_lane_id  out  NB_LANE_ID  detected PCS lane number
o_am_lock  out  1  AM lock status

Behaviour:
- Reset (i_reset=0, async): all outputs 0, FSM=SEARCH, all counters 0.
- Pipeline: latency 1 cycle on o_data/o_valid/o_am_flag. o_data updates only on i_enable&i_valid; otherwise it holds. o_valid=0 when i_enable=0.
- AM match (combinational), valid when all hold:
  - sh==2'b10
  - {M0,M1,M2} equals a table entry (IEEE 802.3 Table 82-2)
  - {M4,M5,M6} == ~{M0,M1,M2}
  - BIP3/BIP7 ignored
  - Outputs hit and idx (idx valid only when hit).
- Only cycles with i_enable&i_valid advance anything (the "event" below).
- FSM states: SEARCH, CONFIRM, LOCKED.
  - SEARCH: on event with hit: lane_id<=idx, am_cnt<=0 -> CONFIRM. o_am_flag pulses for this block.
  - CONFIRM: on event, am_cnt++. At the event where am_cnt==AM_PERIOD-1 the block is at the AM position:
    - hit && idx==lane_id -> LOCKED, o_am_lock<=1, am_cnt<=0, o_am_flag pulses.
    - otherwise -> SEARCH, lane_id<=0. That block is not re-evaluated as a first AM.
  - LOCKED: am_cnt counts 0..AM_PERIOD-1 and wraps to 0 after each AM position. At each AM position:
    - match (hit && idx==lane_id): invalid_cnt<=0, o_am_flag pulses.
    - mismatch: invalid_cnt++. If the new value >= max(i_invalid_am_limit,1) -> SEARCH, o_am_lock<=0, lane_id<=0, invalid_cnt<=0. Otherwise stay LOCKED, o_am_flag=0.
- Non-AM-position blocks are never checked in CONFIRM/LOCKED, even if they happen to match.
- i_block_lock low (any state, sampled each clock regardless of event) -> SEARCH next clock, counters and lane_id cleared, o_am_lock 0. This has priority over all transitions.
- o_lane_id updates the same cycle the FSM leaves SEARCH; it is meaningful only when o_am_lock=1.
- Counter widths: am_cnt wraps naturally only when AM_PERIOD is a power of two. The explicit compare to AM_PERIOD-1 is required for other values.
- i_invalid_am_limit is sampled live; a reduction below the current invalid_cnt triggers unlock at the next bad AM.

Decomposition:
- Package pcs_am_pkg holds:
  - AM_TABLE[N_LANES] of 24-bit {M0,M1,M2} (lane0=C1_68_21, lane1=9D_71_8E, lane2=59_4B_E8, ...per 802.3)
  - default AM_PERIOD, N_LANES
  - FSM state localparams
- Sub-module am_match_table: combinational. Inputs are the 66-bit block. Outputs are hit and the NB_LANE_ID idx. It is shared with the future deskew block.

Test Plan (AM_PERIOD=16 for sim):
1. Lane 0 AM {10,C1,68,21,00,3E,97,DE,00} at block 0 and block 16 -> o_am_flag at both (1-cycle latency), o_am_lock=1 one cycle after second AM, o_lane_id=0.
2. First AM lane 1 (9D718E), block 16 carries lane 2 AM -> back to SEARCH, o_am_lock stays 0, o_lane_id=0.
3. Locked on lane 5, limit=3, corrupt AM at positions 32,48 then good at 64 -> lock held, invalid_cnt cleared. Then 3 consecutive bad AMs -> o_am_lock=0 the cycle after the third.
4. Locked; drop i_block_lock for 1 cycle mid-period -> o_am_lock=0 next cycle, reacquire requires two fresh AMs.
5. i_valid gaps (valid every 3rd cycle) and i_enable low for 10 cycles -> AM spacing counted in valid blocks only, lock achieved identically, o_valid=0 while disabled.
6. Assert i_reset=0 asynchronously while LOCKED -> all outputs 0 immediately; AM with bad complement (M4 wrong) never matches.
